// File: rtl/req_ack_checker_if.sv
// Request/acknowledge bus, completion stream and error status seen by the checker.
// The producer (master) drives the bus_* and err_clr nets; the checker (slave) drives the rest.
interface req_ack_checker_if #(
   parameter int DATA_W = 32,
   parameter int LAT_W  = 5
);
   logic              bus_req;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_data;
   logic              err_clr;
   logic              done_valid;
   logic [DATA_W-1:0] done_data;
   logic [LAT_W-1:0]  done_latency;
   logic [3:0]        outstanding;
   logic [15:0]       req_count;
   logic [3:0]        err_flags;
   logic              err_pulse;

   modport master (
      output bus_req, bus_ack, bus_data, err_clr,
      input  done_valid, done_data, done_latency, outstanding, req_count, err_flags, err_pulse
   );

   modport slave (
      input  bus_req, bus_ack, bus_data, err_clr,
      output done_valid, done_data, done_latency, outstanding, req_count, err_flags, err_pulse
   );
endinterface

// File: rtl/req_ack_checker.sv
// In-order req/ack completion stage with latency measurement and sticky protocol-error flags.
// Completion appears one cycle after the ack; no backpressure, so excess requests are dropped as OVERFLOW.
module req_ack_checker #(
   parameter  int DATA_W    = 32,
   parameter  int MAX_OUTST = 2,
   parameter  int TIMEOUT   = 16,
   localparam int LAT_W     = $clog2(TIMEOUT + 1)
) (
   input logic             clk,
   input logic             reset_l,
   req_ack_checker_if.slave bus
);
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [LAT_W-1:0] lat_t;

   logic [DATA_W-1:0] data_q  [MAX_OUTST];
   lat_t              stamp_q [MAX_OUTST];
   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   logic [3:0]        cnt_q, cnt_d;
   lat_t              ts_q;
   logic              req_d_q;
   logic [15:0]       req_cnt_q, req_cnt_d;
   logic [3:0]        err_q, err_d;
   logic              err_pulse_q;
   logic              done_vld_q;
   logic [DATA_W-1:0] done_dat_q;
   lat_t              done_lat_q;

   lat_t       head_age;
   logic       empty, full;
   logic       accept, long_req;
   logic       ack_pop, ack_no_req, to_pop, pop;
   logic       push, overflow;
   logic [3:0] err_new;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(MAX_OUTST - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   always_comb begin
      // Modular difference is exact because a head never lives past TIMEOUT cycles.
      head_age   = ts_q - stamp_q[rd_ptr_q];
      empty      = (cnt_q == 4'd0);
      full       = (cnt_q == 4'(MAX_OUTST));
      accept     = bus.bus_req && !req_d_q;
      long_req   = bus.bus_req && req_d_q;
      ack_pop    = bus.bus_ack && !empty;
      ack_no_req = bus.bus_ack && empty;
      to_pop     = !bus.bus_ack && !empty && (head_age == lat_t'(TIMEOUT));
      pop        = ack_pop || to_pop;
      push       = accept && (!full || pop);
      overflow   = accept && full && !pop;
      err_new    = {long_req, to_pop, overflow, ack_no_req};

      wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d     = cnt_q + 4'(push) - 4'(pop);
      req_cnt_d = (push && (req_cnt_q != 16'hffff)) ? req_cnt_q + 16'd1 : req_cnt_q;
      // A fresh error in the clearing cycle survives the clear.
      err_d     = (bus.err_clr ? 4'b0000 : err_q) | err_new;
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         for (int i = 0; i < MAX_OUTST; i++) begin
            data_q[i]  <= '0;
            stamp_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ts_q        <= '0;
         req_d_q     <= 1'b0;
         req_cnt_q   <= '0;
         err_q       <= '0;
         err_pulse_q <= 1'b0;
         done_vld_q  <= 1'b0;
         done_dat_q  <= '0;
         done_lat_q  <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q]  <= bus.bus_data;
            stamp_q[wr_ptr_q] <= ts_q;
         end
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         ts_q        <= ts_q + lat_t'(1);
         req_d_q     <= bus.bus_req;
         req_cnt_q   <= req_cnt_d;
         err_q       <= err_d;
         err_pulse_q <= |err_new;
         done_vld_q  <= ack_pop;
         if (ack_pop) begin
            done_dat_q <= data_q[rd_ptr_q];
            done_lat_q <= head_age;
         end
      end
   end

   assign bus.done_valid   = done_vld_q;
   assign bus.done_data    = done_dat_q;
   assign bus.done_latency = done_lat_q;
   assign bus.outstanding  = cnt_q;
   assign bus.req_count    = req_cnt_q;
   assign bus.err_flags    = err_q;
   assign bus.err_pulse    = err_pulse_q;
endmodule

// File: tb/tb_req_ack_checker.sv
// Directed bench for req_ack_checker: completions go through an expected-queue scoreboard,
// status outputs are compared inline against hand-computed values.
module tb_req_ack_checker;
   localparam int DATA_W    = 32;
   localparam int MAX_OUTST = 2;
   localparam int TIMEOUT   = 6;
   localparam int LAT_W     = $clog2(TIMEOUT + 1);

   logic clk     = 1'b0;
   logic reset_l = 1'b0;
   always #5 clk = ~clk;

   req_ack_checker_if #(.DATA_W(DATA_W), .LAT_W(LAT_W)) bus ();

   req_ack_checker #(.DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .reset_l (reset_l),
      .bus     (bus)
   );

   typedef struct packed {
      logic [DATA_W-1:0] dat;
      logic [LAT_W-1:0]  lat;
   } cpl_t;

   cpl_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cpl(input logic [DATA_W-1:0] dat, input logic [LAT_W-1:0] lat);
      cpl_t c;
      c.dat = dat;
      c.lat = lat;
      exp_q.push_back(c);
   endtask

   // Completion monitor: every done_valid pulse must match the oldest expected entry.
   initial begin
      forever begin
         cpl_t e;
         @(posedge clk);
         #1;
         if (bus.done_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got data %0h, expected no completion", bus.done_data);
            end else begin
               e = exp_q.pop_front();
               check("done_data", bus.done_data, e.dat);
               check("done_latency", 32'(bus.done_latency), 32'(e.lat));
            end
         end
      end
   end

   initial begin
      bus.bus_req  = 1'b0;
      bus.bus_ack  = 1'b0;
      bus.bus_data = '0;
      bus.err_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outstanding", 32'(bus.outstanding), 0);
      check("rst_req_count", 32'(bus.req_count), 0);
      check("rst_err_flags", 32'(bus.err_flags), 0);
      check("rst_done_valid", 32'(bus.done_valid), 0);
      check("rst_err_pulse", 32'(bus.err_pulse), 0);
      reset_l = 1'b1;
      cyc();

      // Basic flow: ack two cycles after the request.
      bus.bus_req = 1'b1; bus.bus_data = 32'hfeed;
      cyc();
      bus.bus_req = 1'b0;
      check("t1_outstanding", 32'(bus.outstanding), 1);
      check("t1_req_count", 32'(bus.req_count), 1);
      cyc();
      bus.bus_ack = 1'b1; expect_cpl(32'hfeed, 3'd2);
      cyc();
      bus.bus_ack = 1'b0;
      check("t1_err_flags", 32'(bus.err_flags), 0);
      check("t1_outstanding_after", 32'(bus.outstanding), 0);
      cyc();

      // Ack with nothing outstanding.
      bus.bus_ack = 1'b1;
      cyc();
      bus.bus_ack = 1'b0;
      check("t2_err_flags", 32'(bus.err_flags), 4'b0001);
      check("t2_err_pulse", 32'(bus.err_pulse), 1);
      cyc();
      check("t2_err_pulse_drop", 32'(bus.err_pulse), 0);
      check("t2_err_sticky", 32'(bus.err_flags), 4'b0001);
      bus.err_clr = 1'b1;
      cyc();
      bus.err_clr = 1'b0;
      check("t2_err_clr", 32'(bus.err_flags), 0);

      // Three requests into a two-entry FIFO: the third overflows.
      bus.bus_req = 1'b1; bus.bus_data = 32'haaaa;
      cyc(); bus.bus_req = 1'b0;
      cyc(); bus.bus_req = 1'b1; bus.bus_data = 32'hbbbb;
      cyc(); bus.bus_req = 1'b0;
      cyc(); bus.bus_req = 1'b1; bus.bus_data = 32'hcccc;
      cyc(); bus.bus_req = 1'b0;
      check("t3_err_flags", 32'(bus.err_flags), 4'b0010);
      check("t3_outstanding", 32'(bus.outstanding), 2);
      check("t3_err_pulse", 32'(bus.err_pulse), 1);
      check("t3_req_count", 32'(bus.req_count), 3);
      bus.bus_ack = 1'b1; expect_cpl(32'haaaa, 3'd5);
      cyc(); bus.bus_ack = 1'b0;
      cyc(); bus.bus_ack = 1'b1; expect_cpl(32'hbbbb, 3'd5);
      cyc(); bus.bus_ack = 1'b0;
      check("t3_drained", 32'(bus.outstanding), 0);
      check("t3_flags_kept", 32'(bus.err_flags), 4'b0010);
      bus.err_clr = 1'b1;
      cyc(); bus.err_clr = 1'b0;

      // Unanswered request times out after TIMEOUT cycles; a late ack is then illegal.
      bus.bus_req = 1'b1; bus.bus_data = 32'h4444;
      cyc(); bus.bus_req = 1'b0;
      repeat (5) cyc();
      check("t4_before_timeout_outst", 32'(bus.outstanding), 1);
      check("t4_before_timeout_flags", 32'(bus.err_flags), 0);
      cyc();
      check("t4_timeout_flags", 32'(bus.err_flags), 4'b0100);
      check("t4_timeout_outst", 32'(bus.outstanding), 0);
      check("t4_timeout_pulse", 32'(bus.err_pulse), 1);
      bus.bus_ack = 1'b1;
      cyc(); bus.bus_ack = 1'b0;
      check("t4_late_ack_flags", 32'(bus.err_flags), 4'b0101);
      bus.err_clr = 1'b1;
      cyc(); bus.err_clr = 1'b0;

      // Request held high for three cycles: one push plus LONG_REQ.
      bus.bus_req = 1'b1; bus.bus_data = 32'h5555;
      cyc(); cyc(); cyc();
      bus.bus_req = 1'b0;
      check("t5_err_flags", 32'(bus.err_flags), 4'b1000);
      check("t5_outstanding", 32'(bus.outstanding), 1);
      check("t5_req_count", 32'(bus.req_count), 5);
      bus.bus_ack = 1'b1; expect_cpl(32'h5555, 3'd3);
      cyc(); bus.bus_ack = 1'b0;
      check("t5_drained", 32'(bus.outstanding), 0);
      bus.err_clr = 1'b1;
      cyc(); bus.err_clr = 1'b0;
      check("t5_err_clr", 32'(bus.err_flags), 0);

      // Full FIFO with simultaneous request and ack.
      bus.bus_req = 1'b1; bus.bus_data = 32'hd0d0;
      cyc(); bus.bus_req = 1'b0;
      cyc(); bus.bus_req = 1'b1; bus.bus_data = 32'he0e0;
      cyc(); bus.bus_req = 1'b0;
      cyc(); bus.bus_req = 1'b1; bus.bus_data = 32'hf0f0;
      bus.bus_ack = 1'b1; expect_cpl(32'hd0d0, 3'd4);
      cyc(); bus.bus_req = 1'b0; bus.bus_ack = 1'b0;
      check("t6_outstanding_full", 32'(bus.outstanding), 2);
      check("t6_no_overflow", 32'(bus.err_flags), 0);
      check("t6_req_count", 32'(bus.req_count), 8);
      cyc(); bus.bus_ack = 1'b1; expect_cpl(32'he0e0, 3'd4);
      cyc(); bus.bus_ack = 1'b0;
      check("t6_outstanding_1", 32'(bus.outstanding), 1);
      cyc(); bus.bus_ack = 1'b1; expect_cpl(32'hf0f0, 3'd4);
      cyc(); bus.bus_ack = 1'b0;
      check("t6_outstanding_0", 32'(bus.outstanding), 0);

      // Reset asserted while a completion is showing and an entry is outstanding.
      bus.bus_req = 1'b1; bus.bus_data = 32'h0009;
      cyc(); bus.bus_req = 1'b0;
      cyc(); bus.bus_req = 1'b1; bus.bus_data = 32'h000a;
      cyc(); bus.bus_req = 1'b0;
      bus.bus_ack = 1'b1; expect_cpl(32'h0009, 3'd3);
      cyc(); bus.bus_ack = 1'b0;
      check("rs_outstanding_pre", 32'(bus.outstanding), 1);
      check("rs_req_count_pre", 32'(bus.req_count), 10);
      #1 reset_l = 1'b0;
      #1;
      check("rs_done_valid", 32'(bus.done_valid), 0);
      check("rs_done_data", bus.done_data, 0);
      check("rs_done_latency", 32'(bus.done_latency), 0);
      check("rs_outstanding", 32'(bus.outstanding), 0);
      check("rs_req_count", 32'(bus.req_count), 0);
      check("rs_err_flags", 32'(bus.err_flags), 0);
      @(posedge clk);
      #1 reset_l = 1'b1;
      cyc();
      bus.bus_ack = 1'b1;
      cyc(); bus.bus_ack = 1'b0;
      check("rs_entry_discarded", 32'(bus.err_flags), 4'b0001);
      check("rs_outstanding_post", 32'(bus.outstanding), 0);

      repeat (3) cyc();
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
